// File: rtl/subtrator_serial_ctrl_if.sv
// subtrator_serial_ctrl_if
//   Request/result bundle between a requesting unit and the bit-serial
//   subtractor controller.
//   Optional feature macro: SUBTRATOR_BIN_EN (adds the borrow-in signal bin).
//
//   Signals
//     start   requester -> ctrl  request, sampled only while the controller is idle
//     a, b    requester -> ctrl  minuend / subtrahend, captured on an accepted start
//     bin     requester -> ctrl  borrow-in (SUBTRATOR_BIN_EN only)
//     busy    ctrl -> requester  high while the serial subtraction runs
//     done    ctrl -> requester  one-cycle pulse, diff/borrow valid
//     diff    ctrl -> requester  (a - b - bin) mod 2^WIDTH
//     borrow  ctrl -> requester  final borrow out
//
//   Modports: master = requesting unit, slave = controller.
interface subtrator_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SUBTRATOR_BIN_EN
  logic             bin;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
`ifdef SUBTRATOR_BIN_EN
    output bin,
`endif
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
`ifdef SUBTRATOR_BIN_EN
    input  bin,
`endif
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/subtrator_serial_ctrl.sv
// subtrator_serial_ctrl
//   Bit-serial WIDTH-bit subtractor controller. One 1-bit full subtractor
//   cell (subtratorcompleto) is reused for WIDTH cycles, LSB first, with the
//   cell's borrow out fed back as the next bit's borrow in.
//   Optional feature macro: SUBTRATOR_BIN_EN adds a borrow-in (bus.bin) used
//   as the initial cin, allowing multi-word chaining; without it cin starts at 0.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset (aborts any running subtraction)
//     bus   subtrator_serial_ctrl_if.slave: start/a/b(/bin) in,
//           busy/done/diff/borrow out
//
//   Parameters
//     WIDTH operand/result width, 1..32

// 1-bit full subtractor: s = a - b - cin (mod 2), cout = borrow out.
module subtratorcompleto (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (~a & (b | cin)) | (b & cin);
endmodule

module subtrator_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  subtrator_serial_ctrl_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_shift;
  logic             init_cin;
  logic             cell_s;
  logic             cell_cout;

`ifdef SUBTRATOR_BIN_EN
  assign init_cin = bus.bin;
`else
  assign init_cin = 1'b0;
`endif

  // The single shared cell always sees the current LSBs and running borrow.
  subtratorcompleto u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (brw_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  // New result bit enters at the MSB so that after WIDTH shifts bit 0 sits at
  // the LSB. Written as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    diff_shift            = diff_q >> 1;
    diff_shift[WIDTH-1]   = cell_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = init_cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        diff_d = diff_shift;
        brw_d  = cell_cout;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and visible results: cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
    end
  end

  // Operand shift registers are always reloaded on an accepted start, so
  // they carry no reset.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
  end

  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = brw_q;
endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
module tb_subtrator_serial_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  subtrator_serial_ctrl_if #(.WIDTH(W)) bus ();

  subtrator_serial_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bin(input logic v);
`ifdef SUBTRATOR_BIN_EN
    bus.bin = v;
`else
    if (v) begin end
`endif
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic binv);
    int e;
    e = int'(av) - int'(bv) - int'(binv);
    return W'(e & ((1 << W) - 1));
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] av, input logic [W-1:0] bv,
                                      input logic binv);
    return (int'(av) < int'(bv) + int'(binv));
  endfunction

  // One transaction: start for one cycle, watch busy/done per cycle, check
  // latency, busy length, result, single-cycle done and post-done stability.
  // With noise set, start and operands are scrambled while busy.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                        input bit noise, input string tag);
    logic [W-1:0] ed;
    logic         eb;
    logic         eff_bin;
    int           lat;
    int           busy_cnt;
    bit           seen;
`ifdef SUBTRATOR_BIN_EN
    eff_bin = binv;
`else
    eff_bin = 1'b0;
`endif
    ed = ref_diff(av, bv, eff_bin);
    eb = ref_borrow(av, bv, eff_bin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    drive_bin(binv);
    lat      = 0;
    busy_cnt = 0;
    seen     = 0;
    while (!seen && lat < 3 * W + 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus.start = 1'b0;
      check({tag, "_excl"}, {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1;
      end else if (noise && bus.busy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        drive_bin(1'($urandom_range(0, 1)));
      end
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_latency"}, lat, W + 1);
    check({tag, "_busy_cycles"}, busy_cnt, W);
    check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
    check({tag, "_borrow"}, {31'd0, bus.borrow}, {31'd0, eb});
    @(negedge clk);
    check({tag, "_done_pulse"}, {30'd0, bus.busy, bus.done}, 32'd0);
    check({tag, "_diff_hold"}, 32'(bus.diff), 32'(ed));
  endtask

  task automatic idle_hold(input int n, input string tag);
    logic [W-1:0] d0;
    logic         b0;
    d0 = bus.diff;
    b0 = bus.borrow;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_idle_ctrl"}, {30'd0, bus.busy, bus.done}, 32'd0);
      check({tag, "_idle_diff"}, {23'd0, bus.borrow, bus.diff}, {23'd0, b0, d0});
    end
  endtask

  logic [W-1:0] corner [5];
  logic [W-1:0] ra, rb;
  int           done_idx [$];
  int           idx;

  initial begin
    n_cmp = 0;
    n_err = 0;
    corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F; corner[3] = 8'h80; corner[4] = 8'hFF;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    drive_bin(1'b0);
    repeat (3) @(negedge clk);
    check("reset_ctrl", {30'd0, bus.busy, bus.done}, 32'd0);
    check("reset_data", {23'd0, bus.borrow, bus.diff}, 32'd0);
    rst = 1'b0;
    idle_hold(2, "post_reset");

    // Directed cases from the datasheet examples.
    run_op(8'h05, 8'h03, 1'b0, 0, "t1");
    check("t1_const", {23'd0, bus.borrow, bus.diff}, {23'd0, 1'b0, 8'h02});
    run_op(8'h03, 8'h05, 1'b0, 0, "t2a");
    check("t2a_const", {23'd0, bus.borrow, bus.diff}, {23'd0, 1'b1, 8'hFE});
    run_op(8'h00, 8'h01, 1'b0, 0, "t2b");
    check("t2b_const", {23'd0, bus.borrow, bus.diff}, {23'd0, 1'b1, 8'hFF});
    run_op(8'hFF, 8'hFF, 1'b0, 0, "t2c");
    check("t2c_const", {23'd0, bus.borrow, bus.diff}, {23'd0, 1'b0, 8'h00});
    idle_hold(3, "t2_hold");

    // start held high: accepted only from idle, one result every W+2 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h0A;
    bus.b     = 8'h01;
    idx = 0;
    done_idx.delete();
    while (done_idx.size() < 3 && idx < 60) begin
      @(negedge clk);
      idx++;
      check("t3_excl", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.done) begin
        done_idx.push_back(idx);
        check("t3_diff", 32'(bus.diff), 32'h09);
        check("t3_borrow", {31'd0, bus.borrow}, 32'd0);
        bus.a = 8'h0A;
        bus.b = 8'h01;
        if (done_idx.size() == 3) bus.start = 1'b0;
      end else if (bus.busy) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
    end
    bus.start = 1'b0;
    check("t3_done_count", done_idx.size(), 3);
    if (done_idx.size() == 3) begin
      check("t3_first", done_idx[0], W + 1);
      check("t3_space1", done_idx[1] - done_idx[0], W + 2);
      check("t3_space2", done_idx[2] - done_idx[1], W + 2);
    end
    idle_hold(3, "t3_hold");

    // Asynchronous reset in the middle of a run (after bits 0..3).
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hC7;
    bus.b     = 8'h21;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    check("t4_busy_before", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_ctrl", {30'd0, bus.busy, bus.done}, 32'd0);
    check("t4_rst_data", {23'd0, bus.borrow, bus.diff}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      check("t4_no_done", {30'd0, bus.busy, bus.done}, 32'd0);
    end
    run_op(8'h40, 8'h0F, 1'b0, 0, "t4_fresh");

`ifdef SUBTRATOR_BIN_EN
    run_op(8'h10, 8'h0F, 1'b1, 0, "t5a");
    check("t5a_const", {23'd0, bus.borrow, bus.diff}, {23'd0, 1'b0, 8'h00});
    run_op(8'h00, 8'h00, 1'b1, 0, "t5b");
    check("t5b_const", {23'd0, bus.borrow, bus.diff}, {23'd0, 1'b1, 8'hFF});
`endif

    // Randomized operands, corner values mixed in, optional start noise.
    for (int n = 0; n < 250; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : W'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rnd");
      idle_hold($urandom_range(0, 3), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
